// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - register file bus bundle; scoreboard signals present under RF_SCOREBOARD_EN
interface regfile_multiport_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0] addr_read;
    logic [NUM_READ-1:0]            en_read;
    logic [NUM_READ*DATA_WIDTH-1:0] data_read;
    logic [ADDR_WIDTH-1:0]          addr_write;
    logic [DATA_WIDTH-1:0]          data_write;
    logic                           en_write;
    logic                           clear;
    logic                           ready;
`ifdef RF_SCOREBOARD_EN
    logic                           reserve_en;
    logic [ADDR_WIDTH-1:0]          reserve_addr;
    logic [NUM_READ-1:0]            pending;
`endif

    modport master (
        output addr_read, en_read, addr_write, data_write, en_write, clear,
`ifdef RF_SCOREBOARD_EN
        output reserve_en, reserve_addr,
        input  pending,
`endif
        input  data_read, ready
    );

    modport slave (
        input  addr_read, en_read, addr_write, data_write, en_write, clear,
`ifdef RF_SCOREBOARD_EN
        input  reserve_en, reserve_addr,
        output pending,
`endif
        output data_read, ready
    );
endinterface

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multi-read-port register file with clear sequencer; optional scoreboard under RF_SCOREBOARD_EN
module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    regfile_multiport_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    write_accept;
    logic [ADDR_WIDTH-1:0]   rd_addr [NUM_READ];
    logic [DATA_WIDTH-1:0]   rd_next [NUM_READ];

    // A write lands only in READY, outside reset, when no clear is starting and it does not target the zero register
    always_comb begin
        write_accept = iRst_n && (state == S_READY) && !bus.clear && bus.en_write
                       && !((ZERO_REG != 0) && (bus.addr_write == '0));
    end

    // Per-port read value: zero during clear or on the zero register, else write-first forwarding, else storage
    always_comb begin
        for (int k = 0; k < NUM_READ; k++) begin
            rd_addr[k] = bus.addr_read[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_next[k] = mem[rd_addr[k]];
            if (state == S_CLEAR) begin
                rd_next[k] = '0;
            end else if ((ZERO_REG != 0) && (rd_addr[k] == '0)) begin
                rd_next[k] = '0;
            end else if (write_accept && (bus.addr_write == rd_addr[k])) begin
                rd_next[k] = bus.data_write;
            end
        end
    end

    // Storage: the clear sequencer zeroes one entry per cycle; otherwise accepted writes update the array
    always_ff @(posedge iClk) begin
        if (iRst_n) begin
            if (state == S_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (write_accept) begin
                mem[bus.addr_write] <= bus.data_write;
            end
        end
    end

    // Clear/ready sequencer with registered ready flag and registered read ports
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state         <= S_CLEAR;
            clr_cnt       <= '0;
            bus.ready     <= 1'b0;
            bus.data_read <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state     <= S_READY;
                        bus.ready <= 1'b1;
                    end
                end
                S_READY: begin
                    if (bus.clear) begin
                        state     <= S_CLEAR;
                        clr_cnt   <= '0;
                        bus.ready <= 1'b0;
                    end
                end
                default: state <= S_CLEAR;
            endcase
            for (int k = 0; k < NUM_READ; k++) begin
                if (bus.en_read[k]) begin
                    bus.data_read[k*DATA_WIDTH +: DATA_WIDTH] <= rd_next[k];
                end
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [DEPTH-1:0] pending;

    // Pending bits: wiped by reset and clear, cleared by an accepted write, set by a reserve (reserve wins)
    always_ff @(posedge iClk) begin
        if (!iRst_n || (state == S_CLEAR) || bus.clear) begin
            pending <= '0;
        end else begin
            if (write_accept) begin
                pending[bus.addr_write] <= 1'b0;
            end
            if (bus.reserve_en) begin
                pending[bus.reserve_addr] <= 1'b1;
            end
        end
    end

    // Hazard flags follow the current read addresses combinationally; the zero register is never pending
    always_comb begin
        for (int k = 0; k < NUM_READ; k++) begin
            bus.pending[k] = pending[rd_addr[k]] && !((ZERO_REG != 0) && (rd_addr[k] == '0));
        end
    end
`endif
endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-read-port register file for the processor datapath: N synchronous read ports, one write port, a hardwired zero register and same-cycle write-to-read forwarding. A clear sequencer zeroes every entry after reset or on request. An optional scoreboard tracks registers with outstanding writes for the hazard logic. It sits between decode (read addresses), writeback (write port) and the hazard unit (ready/pending flags).

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2^ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register
- iClk  in  1  clock; all state updates on posedge
- iRst_n  in  1  reset, synchronous, active-low
- iAddrRead  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- iEnRead  in  NUM_READ  per-port read enable
- oDataRead  out  NUM_READ*DATA_WIDTH  packed read data, same packing as iAddrRead
- iAddrWrite  in  ADDR_WIDTH  write address
- iDataWrite  in  DATA_WIDTH  write data
- iEnWrite  in  1  write enable
- iClear  in  1  pulse: start the clear sequence
- oReady  out  1  1 = idle, accepts reads and writes
- iReserveEn, iReserveAddr  in  1, ADDR_WIDTH  mark a register pending (RF_SCOREBOARD_EN only)
- oPending  out  NUM_READ  port k's current address has a pending write (RF_SCOREBOARD_EN only)

## Operation
- FSM states: CLEAR, READY.
- Reset: state = CLEAR, clear counter = 0, oReady = 0, all oDataRead = 0, pending bits = 0.
- CLEAR:
  - Each cycle, writes 0 to entry[counter] and increments the counter.
  - When counter = 2^ADDR_WIDTH-1 is written, the FSM enters READY.
  - iEnWrite and iReserveEn are ignored.
  - Enabled reads return 0. iClear is ignored.
- READY:
  - iClear=1 enters CLEAR with counter = 0. A write in the same cycle is dropped.
  - Otherwise, iEnWrite=1 writes iDataWrite to entry[iAddrWrite] at posedge. If ZERO_REG=1 and iAddrWrite=0, the write is discarded.
- Reads:
  - iEnRead[k]=1 at posedge registers entry[addr_k] into port k's output.
  - iEnRead[k]=0 holds the previous output.
- Forwarding: if iEnWrite=1, the write is accepted, and iAddrWrite equals addr_k in the same cycle, port k returns iDataWrite (write-first).
- Zero register: if ZERO_REG=1 and addr_k=0, port k returns 0 regardless of forwarding.
- Ports are independent. Any number of ports may read the same address in the same cycle.

## Timing
- Read latency: 1 cycle. Address and enable are sampled at edge t; data is valid after edge t and until the next enabled read.
- Write: visible to an enabled read at the same edge (forwarded) and at all later edges.
- Clear:
  - Takes exactly 2^ADDR_WIDTH cycles.
  - With ADDR_WIDTH=5, oReady rises after the 32nd posedge following reset release or iClear.
- Reset asserted mid-CLEAR: the sequence restarts from counter 0 with a full 2^ADDR_WIDTH cycles.
- oReady is registered and is low from the posedge that samples iClear.

## Configuration
- RF_SCOREBOARD_EN defined: the block adds a 2^ADDR_WIDTH-bit pending vector.
  - iReserveEn=1 in READY sets pending[iReserveAddr].
  - An accepted write clears pending[iAddrWrite].
  - Reserve and write to the same address in one cycle: the bit ends set (reserve wins).
  - oPending[k] = pending[addr_k], combinational from the current iAddrRead. It is forced 0 for entry 0 when ZERO_REG=1.
  - CLEAR and reset zero all pending bits.
- RF_SCOREBOARD_EN undefined: iReserveEn, iReserveAddr and oPending do not exist, and no pending state is built.

## Test plan
- Reset, then poll oReady → oReady=0 for 32 cycles, then 1. Reads of all 32 entries return 0.
- Write 0xDEADBEEF to r7. The next cycle, read r7 on port 0 and r3 on port 1 → 0xDEADBEEF and 0x00000000.
- In one cycle, write 0x12345678 to r9 and read r9 on both ports → both return 0x12345678 (forwarding). With iEnRead=0 on the next cycle, both outputs hold.
- ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 → 0. Repeat with ZERO_REG=0 → 0xFFFFFFFF.
- Fill r1..r31 with nonzero values, pulse iClear, and assert iRst_n=0 at cycle 10 of the clear → oReady stays low for a full 32 cycles after release. All registers read 0, and writes issued during CLEAR have no effect.
- RF_SCOREBOARD_EN: reserve r5 → oPending=1 for a port addressing r5. Writing r5 clears it the next cycle. Reserve and write r5 in the same cycle → pending stays 1.
